cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Sits directly downstream of the instruction and data caches of one core.
//  Merges the icache fetch port and the dcache load/store port onto the single RAM port.
//  Grants one request at a time with dcache priority and a bounded-streak anti-starvation rule.
//  Returns wait/load to the granted cache.
// PARAMETERS
//  MAX_DSTREAK  4    consecutive dcache grants allowed while iREN pending; next grant forced to icache
//  TIMEOUT      64   cycles in a service state without ACCESS before abort (counter width $clog2(TIMEOUT+1))
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   reset, asynchronous, active-high
//  iREN      in   1   icache read request
//  iaddr     in   32  icache word address
//  iwait     out  1   0 = iload valid this cycle
//  iload     out  32  instruction word to icache
//  dREN      in   1   dcache read request
//  dWEN      in   1   dcache write request
//  daddr     in   32  dcache word address
//  dstore    in   32  dcache write data
//  dwait     out  1   0 = read data valid / write accepted this cycle
//  dload     out  32  data word to dcache
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address
//  ramstore  out  32  RAM write data
//  ramload   in   32  RAM read data
//  ramstate  in   2   FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  err       out  1   sticky: ramstate==ERROR or timeout seen; cleared only by RST
// BEHAVIOUR
//  - FSM states: IDLE, SERV_D, SERV_I. State, dstreak and tcnt are registered.
//    ram* outputs are combinational from state and the live request lines.
//  - Caches hold addr/data stable while their wait is high.
//  - IDLE selection, taking effect next cycle:
//    - if (dREN|dWEN) and !(iREN && dstreak==MAX_DSTREAK) -> SERV_D
//    - else if iREN -> SERV_I
//    - else stay in IDLE.
//  - dstreak:
//    - increments on an SERV_D entry made while iREN=1, saturating at MAX_DSTREAK.
//    - clears on any SERV_I entry and on an SERV_D entry made with iREN=0.
//  - SERV_D:
//    - ramaddr=daddr, ramstore=dstore.
//    - ramWEN=dWEN, ramREN=dREN&~dWEN. If both are asserted, the write wins.
//  - SERV_I: ramaddr=iiaddr, ramREN=1, ramWEN=0, ramstore=0.
//  - IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0.
//  - Completion: ramstate==ACCESS in a service state.
//    - The granted wait goes 0 in that same cycle; load = ramload (passthrough).
//    - FSM returns to IDLE, so there is one bubble cycle between grants.
//  - Non-granted wait=1 always. The non-granted load and all loads outside completion are 0.
//  - ramstate==ERROR in a service state: err<=1, wait stays 1, FSM -> IDLE (request re-arbitrated).
//  - Timeout:
//    - tcnt clears on service entry and increments each service cycle.
//    - At tcnt==TIMEOUT-1 with no ACCESS: err<=1, FSM -> IDLE, wait stays 1.
//  - Request withdrawn mid-service: the granted request line drops -> IDLE next cycle.
//    ram enables drop combinationally in the same cycle; no completion is signalled.
//  - Latency: request at cycle N in IDLE -> ram enables at N+1.
//    With zero-wait RAM (ACCESS at N+1) the wait low is at N+1.
//  - Reset (async, any state, including mid-service):
//    - state=IDLE, dstreak=0, tcnt=0, err=0.
//    - iwait=dwait=1, loads=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
// STRUCTURE
//  - cpu_types_pkg gets: word_t (32-bit); ramstate_t enum {FREE,BUSY,ACCESS,ERROR};
//    arb_state_t enum {IDLE,SERV_D,SERV_I}.
//  - No sub-module: one FSM always_ff with streak/timeout counters, plus one always_comb output block.
// TESTING
//  1. Reset held, dREN=1 -> dwait=1, ramREN=0. Release RST -> SERV_D next cycle.
//  2. dREN@daddr=0x40, RAM ACCESS 2 cycles after grant, ramload=0xDEAD -> dwait low exactly 1 cycle, dload=0xDEAD.
//  3. iREN and dREN held together, zero-wait RAM -> grants D,D,D,D,I,D,...; iwait low on 5th completion.
//  4. dWEN=1 daddr=0x80 dstore=0x1234 -> ramWEN=1 ramaddr=0x80 ramstore=0x1234.
//     Same-cycle dREN=1 adds ramREN=0.
//  5. ramstate held BUSY 64 cycles in SERV_I -> err=1, FSM IDLE, iwait never low. Then ACCESS -> next fetch completes.
//  6. RST asserted mid-SERV_D -> all outputs return to reset values in the same cycle (async), dstreak=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/memory arbiter: data word, RAM handshake state, arbiter FSM state.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_D = 2'd1,
        SERV_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Merges the icache fetch port and dcache load/store port onto one RAM port.
// dcache wins by default; after MAX_DSTREAK back-to-back dcache grants with a fetch
// pending, the next grant goes to the icache. A stalled service aborts after TIMEOUT cycles.
module cache_mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX_DSTREAK = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int unsigned STREAK_W = $clog2(MAX_DSTREAK + 1);
    localparam int unsigned TCNT_W   = $clog2(TIMEOUT + 1);

    arb_state_t          state_q,   state_d;
    logic [STREAK_W-1:0] dstreak_q, dstreak_d;
    logic [TCNT_W-1:0]   tcnt_q,    tcnt_d;
    logic                err_q,     err_d;

    ramstate_t rs;
    logic      d_req;
    logic      streak_full;
    logic      granted_req;
    logic      timed_out;

    assign rs          = ramstate_t'(ramstate);
    assign d_req       = dREN | dWEN;
    assign streak_full = (dstreak_q == STREAK_W'(MAX_DSTREAK));
    assign err         = err_q;

    // State, streak, timeout counter and sticky error registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            dstreak_q <= '0;
            tcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
        end
    end

    // Arbitration, service termination, streak and timeout bookkeeping.
    always_comb begin
        state_d     = state_q;
        dstreak_d   = dstreak_q;
        tcnt_d      = tcnt_q;
        err_d       = err_q;
        granted_req = 1'b0;
        timed_out   = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(iREN && streak_full)) begin
                    state_d = SERV_D;
                    tcnt_d  = '0;
                    if (iREN) begin
                        dstreak_d = streak_full ? dstreak_q : dstreak_q + STREAK_W'(1);
                    end else begin
                        dstreak_d = '0;
                    end
                end else if (iREN) begin
                    state_d   = SERV_I;
                    tcnt_d    = '0;
                    dstreak_d = '0;
                end
            end
            SERV_D, SERV_I: begin
                granted_req = (state_q == SERV_D) ? d_req : iREN;
                timed_out   = (tcnt_q == TCNT_W'(TIMEOUT - 1)) && (rs != ACCESS);
                if ((rs == ERROR) || timed_out) begin
                    err_d = 1'b1;
                end
                // Withdrawal, completion, error and timeout all hand the port back.
                if (!granted_req || (rs == ACCESS) || (rs == ERROR) || timed_out) begin
                    state_d = IDLE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM port steering and wait/load return to the granted cache.
    always_comb begin
        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            SERV_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                if (d_req && (rs == ACCESS)) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            SERV_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (iREN && (rs == ACCESS)) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a behavioural owner/streak/age model.
module tb_cache_mem_arbiter;

    localparam int MAXD = 4;
    localparam int TMO  = 64;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    always #5 CLK = ~CLK;

    cache_mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: who owns the RAM port (0 none, 1 dcache, 2 icache), consecutive dcache
    // grants made while a fetch waited, cycles spent in the current service, sticky error.
    int m_owner, m_streak, m_age;
    bit m_err;

    task automatic model_reset();
        m_owner = 0; m_streak = 0; m_age = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit dreq, req, acc, er, late;
        dreq = dREN || dWEN;
        if (RST) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (dreq && !(iREN && m_streak >= MAXD)) begin
                m_owner  = 1;
                m_streak = iREN ? ((m_streak < MAXD) ? m_streak + 1 : MAXD) : 0;
                m_age    = 0;
            end else if (iREN) begin
                m_owner  = 2;
                m_streak = 0;
                m_age    = 0;
            end
        end else begin
            req  = (m_owner == 1) ? dreq : iREN;
            acc  = (ramstate == 2'd2);
            er   = (ramstate == 2'd3);
            late = !acc && (m_age == TMO - 1);
            if (er || late) m_err = 1;
            if (!req || acc || er || late) m_owner = 0;
            else m_age++;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] e_iload, e_dload, e_addr, e_store;
        logic        e_iwait, e_dwait, e_ren, e_wen;
        if (RST) model_reset();
        e_iwait = 1; e_dwait = 1; e_iload = 0; e_dload = 0;
        e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
        if (m_owner == 1) begin
            e_addr  = daddr;
            e_store = dstore;
            e_wen   = dWEN;
            e_ren   = dREN && !dWEN;
            if ((dREN || dWEN) && ramstate == 2'd2) begin
                e_dwait = 0;
                e_dload = ramload;
            end
        end else if (m_owner == 2) begin
            e_addr = iaddr;
            e_ren  = iREN;
            if (iREN && ramstate == 2'd2) begin
                e_iwait = 0;
                e_iload = ramload;
            end
        end
        chk("m_iwait", 32'(iwait), 32'(e_iwait));
        chk("m_iload", iload, e_iload);
        chk("m_dwait", 32'(dwait), 32'(e_dwait));
        chk("m_dload", dload, e_dload);
        chk("m_ramREN", 32'(ramREN), 32'(e_ren));
        chk("m_ramWEN", 32'(ramWEN), 32'(e_wen));
        chk("m_ramaddr", ramaddr, e_addr);
        chk("m_ramstore", ramstore, e_store);
        chk("m_err", 32'(err), 32'(m_err));
    endtask

    // One clock: check outputs before the edge, advance the model, return at the falling edge.
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 2'd0;
    endtask

    task automatic do_reset();
        RST = 1;
        cycle();
        RST = 0;
    endtask

    int low, low_at, n, ilow;
    bit done;
    int comp [16];
    int exp_seq [8] = '{1, 1, 1, 1, 2, 1, 1, 1};

    initial begin
        RST = 1;
        idle_inputs();
        model_reset();
        @(negedge CLK);

        // Reset held with a pending load, then release.
        dREN = 1; daddr = 32'h40; ramstate = 2'd1;
        #1;
        chk("t1_dwait_rst", 32'(dwait), 32'd1);
        chk("t1_ramren_rst", 32'(ramREN), 32'd0);
        cycle();
        RST = 0;
        #1;
        chk("t1_ramren_idle", 32'(ramREN), 32'd0);
        cycle();
        #1;
        chk("t1_ramren_grant", 32'(ramREN), 32'd1);
        chk("t1_ramaddr_grant", ramaddr, 32'h40);
        cycle();

        // Load with RAM completing two cycles after grant.
        idle_inputs();
        do_reset();
        dREN = 1; daddr = 32'h40; ramload = 32'hDEAD;
        low = 0; low_at = -1;
        for (int i = 0; i < 5; i++) begin
            ramstate = (i == 3) ? 2'd2 : 2'd1;
            #1;
            if (dwait == 1'b0) begin
                low++;
                low_at = i;
                chk("t2_dload", dload, 32'hDEAD);
            end
            cycle();
        end
        chk("t2_low_count", 32'(low), 32'd1);
        chk("t2_low_cycle", 32'(low_at), 32'd3);

        // Both caches requesting with zero-wait RAM: streak rule.
        idle_inputs();
        do_reset();
        iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; ramstate = 2'd2;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            ramload = $urandom;
            #1;
            if (dwait == 1'b0 && n < 16) begin comp[n] = 1; n++; end
            else if (iwait == 1'b0 && n < 16) begin comp[n] = 2; n++; end
            cycle();
        end
        chk("t3_completions", 32'(n), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < n) chk($sformatf("t3_grant%0d", k), 32'(comp[k]), 32'(exp_seq[k]));
        end

        // Store, then store with a simultaneous load request.
        idle_inputs();
        do_reset();
        dWEN = 1; daddr = 32'h80; dstore = 32'h1234; ramstate = 2'd1;
        cycle();
        #1;
        chk("t4_ramwen", 32'(ramWEN), 32'd1);
        chk("t4_ramren", 32'(ramREN), 32'd0);
        chk("t4_ramaddr", ramaddr, 32'h80);
        chk("t4_ramstore", ramstore, 32'h1234);
        dREN = 1;
        #1;
        chk("t4_both_wen", 32'(ramWEN), 32'd1);
        chk("t4_both_ren", 32'(ramREN), 32'd0);
        cycle();

        // Fetch stalled on BUSY until timeout, then a successful retry.
        idle_inputs();
        do_reset();
        iREN = 1; iaddr = 32'h300; ramstate = 2'd1;
        ilow = 0;
        for (int i = 0; i < 65; i++) begin
            #1;
            if (iwait == 1'b0) ilow++;
            if (i == 64) chk("t5_err_before", 32'(err), 32'd0);
            cycle();
        end
        #1;
        chk("t5_err_after", 32'(err), 32'd1);
        chk("t5_idle_ren", 32'(ramREN), 32'd0);
        chk("t5_iwait_never_low", 32'(ilow), 32'd0);
        ramstate = 2'd2; ramload = 32'hCAFE0001;
        done = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (!done && iwait == 1'b0) begin
                done = 1;
                chk("t5_iload", iload, 32'hCAFE0001);
            end
            cycle();
        end
        chk("t5_refetch", 32'(done), 32'd1);

        // Async reset in the middle of a dcache service with a full streak.
        idle_inputs();
        do_reset();
        iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; ramstate = 2'd2;
        for (int i = 0; i < 6; i++) cycle();
        ramstate = 2'd1;
        cycle();
        #1;
        chk("t6_in_servd_addr", ramaddr, 32'h200);
        chk("t6_in_servd_ren", 32'(ramREN), 32'd1);
        #1;
        RST = 1;
        #1;
        chk("t6_rst_ren", 32'(ramREN), 32'd0);
        chk("t6_rst_addr", ramaddr, 32'd0);
        chk("t6_rst_dwait", 32'(dwait), 32'd1);
        chk("t6_rst_iwait", 32'(iwait), 32'd1);
        cycle();
        RST = 0; ramstate = 2'd2;
        cycle();
        #1;
        chk("t6_streak_cleared", ramaddr, 32'h200);
        chk("t6_dwait_low", 32'(dwait), 32'd0);
        cycle();

        // Randomized traffic against the model.
        idle_inputs();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            int r;
            RST    = ($urandom_range(0, 96) == 0);
            iREN   = ($urandom_range(0, 2) != 0);
            dREN   = ($urandom_range(0, 2) == 0);
            dWEN   = ($urandom_range(0, 3) == 0);
            iaddr  = $urandom;
            daddr  = $urandom;
            dstore = $urandom;
            ramload = $urandom;
            r = $urandom_range(0, 31);
            ramstate = (r < 12) ? 2'd2 : (r < 26) ? 2'd1 : (r < 30) ? 2'd0 : 2'd3;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
